// File: rtl/exe_pkg.sv
// Shared opcode constants, mul/div FSM states and helpers
// for the multi-cycle execute stage.
package exe_pkg;

  localparam logic [5:0] OP_SLL   = 6'h00;
  localparam logic [5:0] OP_SRL   = 6'h02;
  localparam logic [5:0] OP_SRA   = 6'h03;
  localparam logic [5:0] OP_SLLV  = 6'h04;
  localparam logic [5:0] OP_SRLV  = 6'h06;
  localparam logic [5:0] OP_SRAV  = 6'h07;
  localparam logic [5:0] OP_MFHI  = 6'h10;
  localparam logic [5:0] OP_MTHI  = 6'h11;
  localparam logic [5:0] OP_MFLO  = 6'h12;
  localparam logic [5:0] OP_MTLO  = 6'h13;
  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV   = 6'h1A;
  localparam logic [5:0] OP_DIVU  = 6'h1B;
  localparam logic [5:0] OP_ADD   = 6'h20;
  localparam logic [5:0] OP_ADDU  = 6'h21;
  localparam logic [5:0] OP_SUB   = 6'h22;
  localparam logic [5:0] OP_SUBU  = 6'h23;
  localparam logic [5:0] OP_AND   = 6'h24;
  localparam logic [5:0] OP_OR    = 6'h25;
  localparam logic [5:0] OP_XOR   = 6'h26;
  localparam logic [5:0] OP_NOR   = 6'h27;
  localparam logic [5:0] OP_SLT   = 6'h2A;
  localparam logic [5:0] OP_SLTU  = 6'h2B;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic is_muldiv(
    input logic [5:0] op
  );
    return op[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/exe_alu.sv
// Single-cycle integer ALU: add/sub, logic,
// set-less-than and shifts.
module exe_alu #(
  parameter int XLEN = 32
) (
  input  logic [5:0]      ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      shamt,
  output logic [XLEN-1:0] y
);
  import exe_pkg::*;

  logic [4:0] vsh;
  assign vsh = a[4:0];

  always_comb begin
    y = '0;
    case (ctrl)
      OP_ADD, OP_ADDU: y = a + b;
      OP_SUB, OP_SUBU: y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      OP_SLT:  y = XLEN'($signed(a) < $signed(b));
      OP_SLTU: y = XLEN'(a < b);
      OP_SLL:  y = b << shamt;
      OP_SRL:  y = b >> shamt;
      OP_SRA:  y = $signed(b) >>> shamt;
      OP_SLLV: y = b << vsh;
      OP_SRLV: y = b >> vsh;
      OP_SRAV: y = $signed(b) >>> vsh;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/exe_stage_mc_muldiv.sv
// Iterative mul/div: one bit per cycle on operand magnitudes,
// sign fix-up and divide-by-zero handling applied at the output.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            clr,
  input  logic            start,
  input  logic            is_signed,
  input  logic            is_div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  localparam int CW = $clog2(XLEN + 1);

  logic [CW-1:0]   cnt;
  logic            run, div_q, neg_q, neg_r, dz;
  logic [XLEN-1:0] acc, quo, dvs, dvd;
  logic            sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   sum, rsh;
  logic [XLEN-1:0] diff, acc_n, quo_n;
  logic            ge;
  logic [2*XLEN-1:0] prod;

  assign sa    = is_signed & a[XLEN-1];
  assign sb    = is_signed & b[XLEN-1];
  assign mag_a = sa ? -a : a;
  assign mag_b = sb ? -b : b;

  assign sum  = {1'b0, acc} + {1'b0, (quo[0] ? dvs : '0)};
  assign rsh  = {acc, quo[XLEN-1]};
  assign ge   = rsh >= {1'b0, dvs};
  assign diff = rsh[XLEN-1:0] - dvs;

  always_comb begin
    if (div_q) begin
      acc_n = ge ? diff : rsh[XLEN-1:0];
      quo_n = {quo[XLEN-2:0], ge};
    end else begin
      acc_n = sum[XLEN:1];
      quo_n = {sum[0], quo[XLEN-1:1]};
    end
  end

  assign prod = neg_q ? -{acc, quo} : {acc, quo};
  assign last = run & (cnt == CW'(1));

  always_comb begin
    hi = prod[2*XLEN-1:XLEN];
    lo = prod[XLEN-1:0];
    if (div_q) begin
      // zero divisor bypasses the sign fix-up entirely
      hi = dz ? dvd : (neg_r ? -acc : acc);
      lo = dz ? '1 : (neg_q ? -quo : quo);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      run   <= 1'b0;
      cnt   <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
      acc   <= '0;
      quo   <= '0;
      dvs   <= '0;
      dvd   <= '0;
    end else if (clr) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run   <= 1'b1;
      cnt   <= CW'(XLEN);
      div_q <= is_div;
      neg_q <= sa ^ sb;
      neg_r <= sa;
      dz    <= is_div & (b == '0);
      acc   <= '0;
      quo   <= mag_a;
      dvs   <= mag_b;
      dvd   <= a;
    end else if (run && cnt != '0) begin
      acc <= acc_n;
      quo <= quo_n;
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/exe_stage_mc.sv
// Multi-cycle execute stage: forwarding, valid/ready handshake,
// single-cycle ALU and iterative mul/div owning HI/LO.
module exe_stage_mc #(
  parameter int XLEN  = 32,
  parameter int REGW  = 5,
  parameter int CTRLW = 6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      Instr_IN,
  input  logic [31:0]      PC_IN,
  input  logic [REGW-1:0]  RegA_IN,
  input  logic [REGW-1:0]  RegB_IN,
  input  logic [XLEN-1:0]  OpA_IN,
  input  logic [XLEN-1:0]  OpB_IN,
  input  logic [REGW-1:0]  WriteReg_IN,
  input  logic [XLEN-1:0]  StoreData_IN,
  input  logic             RegWrite_IN,
  input  logic             MemRead_IN,
  input  logic             MemWrite_IN,
  input  logic [CTRLW-1:0] ALU_Control_IN,
  input  logic [4:0]       ShiftAmount_IN,
  input  logic [REGW-1:0]  BypReg_IN,
  input  logic [XLEN-1:0]  BypData_IN,
  input  logic             BypValid_IN,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      Instr_OUT,
  output logic [31:0]      PC_OUT,
  output logic [XLEN-1:0]  ALU_result_OUT,
  output logic [REGW-1:0]  WriteReg_OUT,
  output logic [XLEN-1:0]  MemWriteData_OUT,
  output logic             RegWrite_OUT,
  output logic             MemRead_OUT,
  output logic             MemWrite_OUT,
  output logic [CTRLW-1:0] ALU_Control_OUT,
  output logic [XLEN-1:0]  Fwd_data,
  output logic             Fwd_valid,
  output logic             Busy
);
  import exe_pkg::*;

  md_state_e       state;
  logic [5:0]      op;
  logic            is_md, accept, slot_free;
  logic            md_start, commit, load_sc;
  logic            own_ok, md_last;
  logic [XLEN-1:0] op_a, op_b, op_s;
  logic [XLEN-1:0] alu_y, res;
  logic [XLEN-1:0] hi_q, lo_q, md_hi, md_lo;
  logic [31:0]      md_instr, md_pc;
  logic [CTRLW-1:0] md_ctrl;
  logic [REGW-1:0]  md_wr;

  assign op        = ALU_Control_IN[5:0];
  assign is_md     = is_muldiv(op);
  assign slot_free = !out_valid | out_ready;
  assign in_ready  = (state == MD_IDLE) & slot_free;
  assign accept    = in_valid & in_ready;
  assign md_start  = accept & is_md & !FLUSH;
  assign load_sc   = accept & !is_md & !FLUSH;
  assign commit    = (state == MD_DONE) & slot_free & !FLUSH;
  assign Busy      = state != MD_IDLE;
  assign own_ok    = out_valid & RegWrite_OUT
                   & !(MemRead_OUT | MemWrite_OUT);

  function automatic logic [XLEN-1:0] pick(
    input logic [REGW-1:0] idx,
    input logic [XLEN-1:0] v
  );
    if (idx == '0) return v;
    if (own_ok && idx == WriteReg_OUT) return ALU_result_OUT;
    if (BypValid_IN && idx == BypReg_IN) return BypData_IN;
    return v;
  endfunction

  always_comb begin
    op_a = pick(RegA_IN, OpA_IN);
    op_b = pick(RegB_IN, OpB_IN);
    op_s = pick(WriteReg_IN, StoreData_IN);
  end

  exe_alu #(.XLEN(XLEN)) u_alu (
    .ctrl  (op),
    .a     (op_a),
    .b     (op_b),
    .shamt (ShiftAmount_IN),
    .y     (alu_y)
  );

  muldiv_iter #(.XLEN(XLEN)) u_md (
    .CLK       (CLK),
    .RESET     (RESET),
    .clr       (FLUSH | commit),
    .start     (md_start),
    .is_signed (!op[0]),
    .is_div    (op[1]),
    .a         (op_a),
    .b         (op_b),
    .last      (md_last),
    .hi        (md_hi),
    .lo        (md_lo)
  );

  always_comb begin
    res = alu_y;
    unique case (1'b1)
      op == OP_MFHI: res = hi_q;
      op == OP_MFLO: res = lo_q;
      op == OP_MTHI,
      op == OP_MTLO: res = op_a;
      default:       res = alu_y;
    endcase
  end

  assign Fwd_data  = res;
  assign Fwd_valid = accept & RegWrite_IN & !is_md
                   & !(MemRead_IN | MemWrite_IN);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= MD_IDLE;
    end else if (FLUSH) begin
      state <= MD_IDLE;
    end else begin
      unique case (state)
        MD_IDLE: if (md_start)  state <= MD_BUSY;
        MD_BUSY: if (md_last)   state <= MD_DONE;
        MD_DONE: if (slot_free) state <= MD_IDLE;
        default:                state <= MD_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hi_q     <= '0;
      lo_q     <= '0;
      md_instr <= '0;
      md_pc    <= '0;
      md_ctrl  <= '0;
      md_wr    <= '0;
    end else if (!FLUSH) begin
      if (commit) begin
        hi_q <= md_hi;
        lo_q <= md_lo;
      end else if (load_sc && op == OP_MTHI) begin
        hi_q <= op_a;
      end else if (load_sc && op == OP_MTLO) begin
        lo_q <= op_a;
      end
      if (md_start) begin
        md_instr <= Instr_IN;
        md_pc    <= PC_IN;
        md_ctrl  <= ALU_Control_IN;
        md_wr    <= WriteReg_IN;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      out_valid        <= 1'b0;
      Instr_OUT        <= '0;
      PC_OUT           <= '0;
      ALU_result_OUT   <= '0;
      WriteReg_OUT     <= '0;
      MemWriteData_OUT <= '0;
      RegWrite_OUT     <= 1'b0;
      MemRead_OUT      <= 1'b0;
      MemWrite_OUT     <= 1'b0;
      ALU_Control_OUT  <= '0;
    end else if (FLUSH) begin
      out_valid       <= 1'b0;
      RegWrite_OUT    <= 1'b0;
      MemRead_OUT     <= 1'b0;
      MemWrite_OUT    <= 1'b0;
      ALU_Control_OUT <= '0;
    end else if (load_sc) begin
      out_valid        <= 1'b1;
      Instr_OUT        <= Instr_IN;
      PC_OUT           <= PC_IN;
      ALU_result_OUT   <= res;
      WriteReg_OUT     <= WriteReg_IN;
      MemWriteData_OUT <= op_s;
      RegWrite_OUT     <= RegWrite_IN;
      MemRead_OUT      <= MemRead_IN;
      MemWrite_OUT     <= MemWrite_IN;
      ALU_Control_OUT  <= ALU_Control_IN;
    end else if (commit) begin
      // non-writing bubble so the mul/div retires downstream
      out_valid        <= 1'b1;
      Instr_OUT        <= md_instr;
      PC_OUT           <= md_pc;
      ALU_result_OUT   <= md_lo;
      WriteReg_OUT     <= md_wr;
      MemWriteData_OUT <= '0;
      RegWrite_OUT     <= 1'b0;
      MemRead_OUT      <= 1'b0;
      MemWrite_OUT     <= 1'b0;
      ALU_Control_OUT  <= md_ctrl;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed bench for exe_stage_mc: ALU, forwarding, mul/div,
// back-pressure, flush and reset.
module tb_exe_stage_mc;
  import exe_pkg::*;

  localparam int XLEN  = 32;
  localparam int REGW  = 5;
  localparam int CTRLW = 6;

  logic             CLK = 0;
  logic             RESET = 0;
  logic             FLUSH = 0;
  logic             in_valid = 0;
  logic             in_ready;
  logic [31:0]      Instr_IN = 0;
  logic [31:0]      PC_IN = 0;
  logic [REGW-1:0]  RegA_IN = 0;
  logic [REGW-1:0]  RegB_IN = 0;
  logic [XLEN-1:0]  OpA_IN = 0;
  logic [XLEN-1:0]  OpB_IN = 0;
  logic [REGW-1:0]  WriteReg_IN = 0;
  logic [XLEN-1:0]  StoreData_IN = 0;
  logic             RegWrite_IN = 0;
  logic             MemRead_IN = 0;
  logic             MemWrite_IN = 0;
  logic [CTRLW-1:0] ALU_Control_IN = 0;
  logic [4:0]       ShiftAmount_IN = 0;
  logic [REGW-1:0]  BypReg_IN = 0;
  logic [XLEN-1:0]  BypData_IN = 0;
  logic             BypValid_IN = 0;
  logic             out_valid;
  logic             out_ready = 1;
  logic [31:0]      Instr_OUT;
  logic [31:0]      PC_OUT;
  logic [XLEN-1:0]  ALU_result_OUT;
  logic [REGW-1:0]  WriteReg_OUT;
  logic [XLEN-1:0]  MemWriteData_OUT;
  logic             RegWrite_OUT;
  logic             MemRead_OUT;
  logic             MemWrite_OUT;
  logic [CTRLW-1:0] ALU_Control_OUT;
  logic [XLEN-1:0]  Fwd_data;
  logic             Fwd_valid;
  logic             Busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  exe_stage_mc #(
    .XLEN(XLEN), .REGW(REGW), .CTRLW(CTRLW)
  ) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .in_valid(in_valid), .in_ready(in_ready),
    .Instr_IN(Instr_IN), .PC_IN(PC_IN),
    .RegA_IN(RegA_IN), .RegB_IN(RegB_IN),
    .OpA_IN(OpA_IN), .OpB_IN(OpB_IN),
    .WriteReg_IN(WriteReg_IN), .StoreData_IN(StoreData_IN),
    .RegWrite_IN(RegWrite_IN), .MemRead_IN(MemRead_IN),
    .MemWrite_IN(MemWrite_IN), .ALU_Control_IN(ALU_Control_IN),
    .ShiftAmount_IN(ShiftAmount_IN),
    .BypReg_IN(BypReg_IN), .BypData_IN(BypData_IN),
    .BypValid_IN(BypValid_IN),
    .out_valid(out_valid), .out_ready(out_ready),
    .Instr_OUT(Instr_OUT), .PC_OUT(PC_OUT),
    .ALU_result_OUT(ALU_result_OUT), .WriteReg_OUT(WriteReg_OUT),
    .MemWriteData_OUT(MemWriteData_OUT),
    .RegWrite_OUT(RegWrite_OUT), .MemRead_OUT(MemRead_OUT),
    .MemWrite_OUT(MemWrite_OUT), .ALU_Control_OUT(ALU_Control_OUT),
    .Fwd_data(Fwd_data), .Fwd_valid(Fwd_valid), .Busy(Busy)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_op(
    input logic [5:0]  op,
    input logic [4:0]  ra,
    input logic [4:0]  rb,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0]  wr,
    input logic        rw
  );
    in_valid       = 1;
    ALU_Control_IN = op;
    RegA_IN        = ra;
    RegB_IN        = rb;
    OpA_IN         = a;
    OpB_IN         = b;
    WriteReg_IN    = wr;
    RegWrite_IN    = rw;
    Instr_IN       = {op, ra, rb, wr, 11'h0};
    PC_IN          = PC_IN + 4;
  endtask

  task automatic idle_in();
    in_valid    = 0;
    RegWrite_IN = 0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    @(negedge CLK);
    while (!in_ready && cyc < 200) begin
      cyc++;
      @(negedge CLK);
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    step();
    set_op(OP_MFHI, 0, 0, 0, 0, 5'd1, 1);
    @(negedge CLK);
    hi = Fwd_data;
    step();
    set_op(OP_MFLO, 0, 0, 0, 0, 5'd1, 1);
    @(negedge CLK);
    lo = Fwd_data;
    step();
    idle_in();
  endtask

  task automatic test_reset();
    logic [31:0] hi, lo;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || Busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hs: out_valid=%b in_ready=%b Busy=%b want 0/1/0",
               out_valid, in_ready, Busy);
    end
    n_cmp++;
    if (ALU_result_OUT !== 0 || RegWrite_OUT !== 0 || Instr_OUT !== 0) begin
      n_err++;
      $display("FAIL reset_regs: res=%h rw=%b instr=%h want 0",
               ALU_result_OUT, RegWrite_OUT, Instr_OUT);
    end
    RESET = 1;
    read_hilo(hi, lo);
    n_cmp++;
    if (hi !== 0 || lo !== 0) begin
      n_err++;
      $display("FAIL reset_hilo: hi=%h lo=%h want 0/0", hi, lo);
    end
  endtask

  task automatic test_add();
    step();
    set_op(OP_ADD, 1, 2, 5, 7, 8, 1);
    @(negedge CLK);
    n_cmp++;
    if (Fwd_valid !== 1'b1 || Fwd_data !== 12 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL add_fwd: fv=%b fd=%0d ov=%b want 1/12/0",
               Fwd_valid, Fwd_data, out_valid);
    end
    step();
    idle_in();
    @(negedge CLK);
    n_cmp++;
    if (out_valid !== 1'b1 || ALU_result_OUT !== 12 ||
        WriteReg_OUT !== 8 || RegWrite_OUT !== 1'b1) begin
      n_err++;
      $display("FAIL add_out: ov=%b res=%0d wr=%0d rw=%b want 1/12/8/1",
               out_valid, ALU_result_OUT, WriteReg_OUT, RegWrite_OUT);
    end
    step();
    @(negedge CLK);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL add_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    step();
    set_op(OP_ADD, 1, 2, 1, 2, 3, 1);
    step();
    set_op(OP_ADD, 3, 3, 0, 0, 4, 1);
    @(negedge CLK);
    n_cmp++;
    if (Fwd_data !== 6) begin
      n_err++;
      $display("FAIL b2b_fwd: Fwd_data=%0d want 6", Fwd_data);
    end
    step();
    idle_in();
    @(negedge CLK);
    n_cmp++;
    if (ALU_result_OUT !== 6 || WriteReg_OUT !== 4) begin
      n_err++;
      $display("FAIL b2b_out: res=%0d wr=%0d want 6/4",
               ALU_result_OUT, WriteReg_OUT);
    end
    step();
    set_op(OP_ADD, 1, 2, 1, 2, 0, 1);
    step();
    set_op(OP_ADD, 0, 0, 0, 0, 5, 1);
    step();
    idle_in();
    @(negedge CLK);
    n_cmp++;
    if (ALU_result_OUT !== 0 || WriteReg_OUT !== 5) begin
      n_err++;
      $display("FAIL b2b_r0: res=%0d wr=%0d want 0/5",
               ALU_result_OUT, WriteReg_OUT);
    end
  endtask

  task automatic test_bypass();
    step();
    BypReg_IN   = 6;
    BypData_IN  = 100;
    BypValid_IN = 1;
    set_op(OP_ADD, 1, 2, 1, 1, 6, 1);
    step();
    set_op(OP_ADD, 6, 2, 0, 10, 9, 1);
    @(negedge CLK);
    n_cmp++;
    if (Fwd_data !== 12) begin
      n_err++;
      $display("FAIL byp_prio: Fwd_data=%0d want 12", Fwd_data);
    end
    step();
    idle_in();
    step();
    set_op(OP_ADD, 6, 2, 0, 10, 9, 1);
    @(negedge CLK);
    n_cmp++;
    if (Fwd_data !== 110) begin
      n_err++;
      $display("FAIL byp_mem: Fwd_data=%0d want 110", Fwd_data);
    end
    step();
    idle_in();
    BypValid_IN = 0;
  endtask

  task automatic test_mult();
    int cyc;
    logic [31:0] exp_instr;
    exp_instr = {OP_MULT, 5'd1, 5'd2, 5'd0, 11'h0};
    step();
    set_op(OP_MULT, 1, 2, 32'hFFFF_FFFF, 2, 0, 0);
    step();
    set_op(OP_MFHI, 0, 0, 0, 0, 5'd7, 1);
    @(negedge CLK);
    n_cmp++;
    if (Busy !== 1'b1 || Fwd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mult_busy: Busy=%b Fwd_valid=%b want 1/0",
               Busy, Fwd_valid);
    end
    cyc = 1;
    @(negedge CLK);
    while (!in_ready && cyc < 200) begin
      cyc++;
      @(negedge CLK);
    end
    n_cmp++;
    if (cyc !== 33) begin
      n_err++;
      $display("FAIL mult_stall: in_ready low %0d cycles want 33", cyc);
    end
    n_cmp++;
    if (out_valid !== 1'b1 || RegWrite_OUT !== 1'b0 ||
        Instr_OUT !== exp_instr || ALU_Control_OUT !== OP_MULT) begin
      n_err++;
      $display("FAIL mult_bubble: ov=%b rw=%b instr=%h ctl=%h want 1/0/%h/%h",
               out_valid, RegWrite_OUT, Instr_OUT, ALU_Control_OUT,
               exp_instr, OP_MULT);
    end
    n_cmp++;
    if (Fwd_data !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL mult_hi: Fwd_data=%h want ffffffff", Fwd_data);
    end
    step();
    set_op(OP_MFLO, 0, 0, 0, 0, 5'd8, 1);
    @(negedge CLK);
    n_cmp++;
    if (Fwd_data !== 32'hFFFF_FFFE || ALU_result_OUT !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL mult_lo: lo=%h prev_res=%h want fffffffe/ffffffff",
               Fwd_data, ALU_result_OUT);
    end
    step();
    idle_in();
  endtask

  task automatic test_div();
    logic [5:0]  ops [3];
    logic [31:0] av [3];
    logic [31:0] bv [3];
    logic [31:0] eh [3];
    logic [31:0] el [3];
    logic [31:0] hi, lo;
    int cyc;
    ops = '{OP_DIV, OP_DIVU, OP_DIV};
    av  = '{32'hFFFF_FFF9, 32'd9, 32'h8000_0000};
    bv  = '{32'd2, 32'd0, 32'hFFFF_FFFF};
    eh  = '{32'hFFFF_FFFF, 32'd9, 32'd0};
    el  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    for (int i = 0; i < 3; i++) begin
      step();
      set_op(ops[i], 1, 2, av[i], bv[i], 0, 0);
      step();
      idle_in();
      wait_ready(cyc);
      n_cmp++;
      if (cyc !== 33) begin
        n_err++;
        $display("FAIL div%0d_lat: %0d cycles want 33", i, cyc);
      end
      read_hilo(hi, lo);
      n_cmp++;
      if (hi !== eh[i] || lo !== el[i]) begin
        n_err++;
        $display("FAIL div%0d: hi=%h lo=%h want %h/%h",
                 i, hi, lo, eh[i], el[i]);
      end
    end
  endtask

  task automatic test_stall();
    step();
    out_ready = 0;
    set_op(OP_ADD, 1, 2, 3, 4, 10, 1);
    step();
    set_op(OP_ADD, 1, 2, 1, 1, 11, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          ALU_result_OUT !== 7 || WriteReg_OUT !== 10) begin
        n_err++;
        $display("FAIL stall_hold%0d: ov=%b ir=%b res=%0d wr=%0d want 1/0/7/10",
                 i, out_valid, in_ready, ALU_result_OUT, WriteReg_OUT);
      end
      step();
    end
    out_ready = 1;
    @(negedge CLK);
    n_cmp++;
    if (in_ready !== 1'b1 || ALU_result_OUT !== 7) begin
      n_err++;
      $display("FAIL stall_release: ir=%b res=%0d want 1/7",
               in_ready, ALU_result_OUT);
    end
    step();
    idle_in();
    @(negedge CLK);
    n_cmp++;
    if (out_valid !== 1'b1 || ALU_result_OUT !== 2 || WriteReg_OUT !== 11) begin
      n_err++;
      $display("FAIL stall_next: ov=%b res=%0d wr=%0d want 1/2/11",
               out_valid, ALU_result_OUT, WriteReg_OUT);
    end
    step();
    @(negedge CLK);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_dup: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    logic [31:0] hi, lo;
    step();
    set_op(OP_MTHI, 1, 0, 32'h0000_AAAA, 0, 0, 0);
    step();
    set_op(OP_MTLO, 1, 0, 32'h0000_5555, 0, 0, 0);
    step();
    set_op(OP_DIV, 1, 2, 100, 7, 0, 0);
    step();
    idle_in();
    repeat (10) step();
    FLUSH = 1;
    step();
    FLUSH = 0;
    @(negedge CLK);
    n_cmp++;
    if (Busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_state: Busy=%b ir=%b ov=%b want 0/1/0",
               Busy, in_ready, out_valid);
    end
    repeat (40) step();
    read_hilo(hi, lo);
    n_cmp++;
    if (hi !== 32'h0000_AAAA || lo !== 32'h0000_5555) begin
      n_err++;
      $display("FAIL flush_hilo: hi=%h lo=%h want 0000aaaa/00005555", hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] hi, lo;
    step();
    set_op(OP_MULTU, 1, 2, 3, 3, 0, 0);
    step();
    idle_in();
    repeat (5) step();
    @(negedge CLK);
    RESET = 0;
    #1;
    n_cmp++;
    if (Busy !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid: Busy=%b ir=%b want 0/1", Busy, in_ready);
    end
    @(negedge CLK);
    RESET = 1;
    repeat (40) step();
    read_hilo(hi, lo);
    n_cmp++;
    if (hi !== 0 || lo !== 0) begin
      n_err++;
      $display("FAIL rst_mid_hilo: hi=%h lo=%h want 0/0", hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_bypass();
    test_mult();
    test_div();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
